load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Downstream of the control unit. Consumes its `cyc`/`memory_operation` request handshake and returns `ack` and `data_valid`.
- Computes the effective address, steers byte lanes, and runs one Wishbone-classic master transaction per request.
- Sign/zero-extends load data for the register-file `LOAD_SRC` mux input.

Parameters:
- TIMEOUT_CYCLES, 255, bus cycles to wait for `wb_ack_i` before aborting with bus_error; 0 disables the timeout.
- RESET_ADDR, 32'h0, reset value of `wb_adr_o`.

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- cyc  in  1  request from control unit; held high until ack seen
- memory_operation  in  memory_operation_t  MEM_NONE / LOAD_DATA / STORE_DATA
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rs1_data  in  32  base address
- offset  in  32  sign-extended immediate (i_imm for loads, s_imm for stores)
- rs2_data  in  32  store data
- ack  out  1  request accepted and bus phase finished
- data_valid  out  1  one-cycle pulse; load_data valid
- load_data  out  32  extended load result; held until next load completes
- bus_error  out  1  sticky until next accepted request; set on timeout or wb_err_i
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master controls
- wb_adr_o  out  32  word-aligned byte address (bits [1:0] = 0)
- wb_sel_o  out  4  byte enables
- wb_dat_o  out  32  lane-shifted store data
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i  in  1  slave termination

Behaviour:
- Reset (rst = 0, async):
  - State IDLE.
  - ack, data_valid, bus_error, wb_cyc_o, wb_stb_o and wb_we_o are 0.
  - load_data = 0; wb_sel_o = 0; wb_dat_o = 0; wb_adr_o = RESET_ADDR.
- States: IDLE, BUS, ACK, VALID.
- IDLE:
  - When cyc = 1 and memory_operation != MEM_NONE, latch addr = rs1_data + offset (mod 2^32), funct3, rs2_data and op.
  - Clear bus_error and go to BUS.
  - cyc with MEM_NONE is ignored.
- BUS:
  - wb_cyc_o = wb_stb_o = 1; wb_we_o = (op == STORE).
  - wb_sel_o lanes:
    - B: 1 << addr[1:0]
    - H: 4'b0011 << (addr[1] * 2)
    - W: 4'b1111
  - wb_dat_o replicates the byte/half into all lanes.
  - Timeout counter clears on entry and increments each BUS cycle.
  - On wb_ack_i: drop wb_cyc_o/wb_stb_o the same edge. For a load, register the extracted lane:
    - B / H: sign-extended
    - BU / HU: zero-extended
    - W: raw
  - On wb_err_i, or counter == TIMEOUT_CYCLES - 1 (when TIMEOUT_CYCLES != 0):
    - Terminate the bus cycle; set bus_error.
    - The load result is 32'h0.
  - Both termination paths go to ACK. wb_ack_i and wb_err_i together count as error.
- ACK:
  - ack = 1 while cyc = 1; ack holds ≥ 1 full cycle so the control unit's negedge sampling sees it.
  - When cyc returns to 0: a load goes to VALID; a store goes to IDLE.
- VALID:
  - data_valid = 1 for exactly one cycle; load_data updates on entry.
  - Next state IDLE. A new request in the same cycle is accepted only from IDLE, i.e. the following cycle.
- Latency: a zero-wait-state slave gives request→ack in 2 cycles; loads add 1 cycle after cyc drops for data_valid.
- Reserved funct3 values (011, 110, 111) are treated as W.
- Inputs are not re-sampled after IDLE; changes mid-operation are ignored.
- Reset asserted mid-BUS drops the Wishbone cycle immediately (async); no ack is issued.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - An H access with addr[0] = 1, or a W access with addr[1:0] != 0, skips BUS and goes straight to ACK.
  - No Wishbone cycle is issued; bus_error = 1; the load result is 0.
  - Output port misaligned (1 bit, sticky like bus_error) is added.
- Undefined:
  - No check. H uses lanes per addr[1] only; W ignores addr[1:0].
  - Port misaligned is absent.

Decomposition:
- global_pkg additions:
  - lsu_state_t enum {IDLE, BUS, ACK, VALID}
  - funct3 constants LS_B = 3'b000, LS_H = 3'b001, LS_W = 3'b010, LS_BU = 3'b100, LS_HU = 3'b101
  - memory_operation_t is reused as-is.
- One combinational sub-module, lsu_align, holds lane select, store replication and load extraction/extension. The FSM, counter and registers stay in load_store_unit.

Test Plan:
- SW: rs1 = 0x100, offset = 4, rs2 = 0xCAFEBABE, slave acks after 3 wait cycles → wb_adr_o = 0x104, wb_sel_o = 1111, wb_we_o = 1, wb_dat_o = 0xCAFEBABE; ack rises 1 cycle after wb_ack_i; no data_valid.
- LB at 0x203, slave returns 0x80123456 → wb_sel_o = 1000, load_data = 0xFFFFFF80, one data_valid pulse after cyc drops. LBU at the same address → 0x00000080.
- LH at 0x202, wb_dat_i = 0x9ABC1234 → wb_sel_o = 1100, load_data = 0xFFFF9ABC. LHU → 0x00009ABC.
- SB at 0x301, rs2 = 0x000000A5 → wb_sel_o = 0010, wb_dat_o = 0xA5A5A5A5.
- Timeout: TIMEOUT_CYCLES = 8, slave never acks → wb_cyc_o drops after 8 BUS cycles, bus_error = 1, ack asserted, load_data = 0; the next accepted request clears bus_error.
- Reset: rst low during BUS → wb_cyc_o = 0 at once, no ack. After rst high, a new LW completes normally. With MISALIGN_TRAP_EN, LW at 0x102 → no wb_cyc_o, misaligned = 1, ack pulses.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: request opcodes, FSM states and funct3 size codes.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MEM_NONE   = 2'd0,
        LOAD_DATA  = 2'd1,
        STORE_DATA = 2'd2
    } memory_operation_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        ACK   = 2'd2,
        VALID = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // funct3[1] set means word (reserved encodings included), so W and reserved share the check.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: Wishbone select, store-data replication and load extraction/extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  sel,
    output logic [31:0] wr_data,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        uns;

    always_comb begin
        byte_v  = rd_data[{addr_lo, 3'b000} +: 8];
        half_v  = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
        uns     = funct3[2];
        sel     = 4'b1111;
        wr_data = st_data;
        ld_data = rd_data;
        // Size comes from funct3[1:0]; 1x (W and all reserved codes) falls to the default.
        case (funct3[1:0])
            2'b00: begin
                sel     = 4'b0001 << addr_lo;
                wr_data = {4{st_data[7:0]}};
                ld_data = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            2'b01: begin
                sel     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{st_data[15:0]}};
                ld_data = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one Wishbone-classic master transaction per control-unit request.
// Optional MISALIGN_TRAP_EN rejects misaligned H/W accesses without touching the bus.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_ADDR     = 32'h0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc,
    input  memory_operation_t memory_operation,
    input  logic [2:0]        funct3,
    input  logic [31:0]       rs1_data,
    input  logic [31:0]       offset,
    input  logic [31:0]       rs2_data,
    output logic              ack,
    output logic              data_valid,
    output logic [31:0]       load_data,
    output logic              bus_error,
`ifdef MISALIGN_TRAP_EN
    output logic              misaligned,
`endif
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [31:0]       wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state;
    logic [1:0]  addr_lo_q;
    logic [2:0]  f3_q;
    logic        is_load_q;
    logic [31:0] ld_q;
    logic [31:0] tmo_cnt;

    logic        req;
    logic [31:0] req_addr;
    logic [1:0]  a_lo;
    logic [2:0]  a_f3;
    logic [3:0]  a_sel;
    logic [31:0] a_wr;
    logic [31:0] a_ld;
    logic        bus_fail;
    logic        trap;

    assign req      = cyc && (memory_operation != MEM_NONE);
    assign req_addr = rs1_data + offset;
    // Aligner sees live inputs while accepting, latched fields once the bus phase runs.
    assign a_lo     = (state == IDLE) ? req_addr[1:0] : addr_lo_q;
    assign a_f3     = (state == IDLE) ? funct3 : f3_q;
    assign bus_fail = wb_err_i || (TO_EN && (tmo_cnt == TO_LAST));

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_align u_align (
        .addr_lo (a_lo),
        .funct3  (a_f3),
        .st_data (rs2_data),
        .rd_data (wb_dat_i),
        .sel     (a_sel),
        .wr_data (a_wr),
        .ld_data (a_ld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_lo_q  <= 2'b00;
            f3_q       <= 3'b000;
            is_load_q  <= 1'b0;
            ld_q       <= 32'h0;
            tmo_cnt    <= 32'h0;
            ack        <= 1'b0;
            data_valid <= 1'b0;
            load_data  <= 32'h0;
            bus_error  <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= RESET_ADDR;
            wb_sel_o   <= 4'h0;
            wb_dat_o   <= 32'h0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    addr_lo_q <= req_addr[1:0];
                    f3_q      <= funct3;
                    is_load_q <= (memory_operation == LOAD_DATA);
                    tmo_cnt   <= 32'h0;
                    if (trap) begin
                        state     <= ACK;
                        ack       <= 1'b1;
                        bus_error <= 1'b1;
                        ld_q      <= 32'h0;
                    end else begin
                        state     <= BUS;
                        bus_error <= 1'b0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= (memory_operation == STORE_DATA);
                        wb_adr_o  <= {req_addr[31:2], 2'b00};
                        wb_sel_o  <= a_sel;
                        wb_dat_o  <= a_wr;
                    end
                end
                BUS: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    // Error wins over a simultaneous ack.
                    if (bus_fail || wb_ack_i) begin
                        state     <= ACK;
                        ack       <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        bus_error <= bus_fail;
                        ld_q      <= bus_fail ? 32'h0 : a_ld;
                    end
                end
                ACK: if (!cyc) begin
                    ack <= 1'b0;
                    if (is_load_q) begin
                        state      <= VALID;
                        data_valid <= 1'b1;
                        load_data  <= ld_q;
                    end else begin
                        state <= IDLE;
                    end
                end
                VALID: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misaligned <= 1'b0;
        else if (state == IDLE && req)
            misaligned <= trap;
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with an inline zero/multi-wait Wishbone slave.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cyc = 1'b0;
    memory_operation_t memory_operation = MEM_NONE;
    logic [2:0]        funct3 = 3'b000;
    logic [31:0]       rs1_data = '0, offset = '0, rs2_data = '0;
    logic              ack, data_valid, bus_error;
    logic [31:0]       load_data;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0]       wb_adr_o, wb_dat_o;
    logic [3:0]        wb_sel_o;
    logic [31:0]       wb_dat_i = '0;
    logic              wb_ack_i = 1'b0, wb_err_i = 1'b0;
`ifdef MISALIGN_TRAP_EN
    logic              misaligned;
`endif

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT_CYCLES(8), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .cyc(cyc), .memory_operation(memory_operation),
        .funct3(funct3), .rs1_data(rs1_data), .offset(offset), .rs2_data(rs2_data),
        .ack(ack), .data_valid(data_valid), .load_data(load_data), .bus_error(bus_error),
`ifdef MISALIGN_TRAP_EN
        .misaligned(misaligned),
`endif
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One full request: accept, optional waits, slave ack, cyc drop, data_valid window.
    task automatic run_req(input string tag, input memory_operation_t op, input logic [2:0] f3,
                           input logic [31:0] base, input logic [31:0] off, input logic [31:0] sdata,
                           input int waits, input logic [31:0] rdata,
                           input logic [31:0] exp_adr, input logic [3:0] exp_sel,
                           input logic [31:0] exp_dat, input logic [31:0] exp_ld);
        logic is_ld;
        is_ld = (op == LOAD_DATA);
        @(negedge clk);
        cyc = 1'b1; memory_operation = op; funct3 = f3;
        rs1_data = base; offset = off; rs2_data = sdata;
        @(negedge clk);
        chk({tag, " cyc"}, 32'(wb_cyc_o), 32'd1);
        chk({tag, " adr"}, wb_adr_o, exp_adr);
        chk({tag, " sel"}, 32'(wb_sel_o), 32'(exp_sel));
        chk({tag, " we"},  32'(wb_we_o), 32'(!is_ld));
        if (!is_ld) chk({tag, " dat"}, wb_dat_o, exp_dat);
        chk({tag, " berr_clr"}, 32'(bus_error), 32'd0);
        // Inputs wander mid-operation; the unit must ignore them.
        rs1_data = 32'hDEAD_0000; funct3 = 3'b000; rs2_data = 32'h0;
        repeat (waits) begin
            chk({tag, " ack_wait"}, 32'(ack), 32'd0);
            @(negedge clk);
        end
        wb_ack_i = 1'b1; wb_dat_i = rdata;
        @(negedge clk);
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        chk({tag, " ack"}, 32'(ack), 32'd1);
        chk({tag, " cyc_drop"}, 32'(wb_cyc_o), 32'd0);
        @(negedge clk);
        chk({tag, " ack_hold"}, 32'(ack), 32'd1);
        cyc = 1'b0; memory_operation = MEM_NONE;
        @(negedge clk);
        chk({tag, " ack_off"}, 32'(ack), 32'd0);
        chk({tag, " dvalid"}, 32'(data_valid), 32'(is_ld));
        if (is_ld) chk({tag, " ldata"}, load_data, exp_ld);
        @(negedge clk);
        chk({tag, " dvalid_off"}, 32'(data_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        chk("rst ack",   32'(ack), 32'd0);
        chk("rst dv",    32'(data_valid), 32'd0);
        chk("rst berr",  32'(bus_error), 32'd0);
        chk("rst cyc",   32'(wb_cyc_o), 32'd0);
        chk("rst stb",   32'(wb_stb_o), 32'd0);
        chk("rst we",    32'(wb_we_o), 32'd0);
        chk("rst ld",    load_data, 32'h0);
        chk("rst adr",   wb_adr_o, 32'h0);
        chk("rst sel",   32'(wb_sel_o), 32'd0);
        chk("rst dat",   wb_dat_o, 32'h0);
        @(negedge clk); rst = 1'b1;

        // cyc with MEM_NONE is ignored
        @(negedge clk); cyc = 1'b1; memory_operation = MEM_NONE;
        @(negedge clk); chk("none cyc", 32'(wb_cyc_o), 32'd0);
        chk("none ack", 32'(ack), 32'd0);
        cyc = 1'b0;

        run_req("SW",   STORE_DATA, LS_W,  32'h100, 32'd4, 32'hCAFEBABE, 3, 32'h0,
                32'h104, 4'b1111, 32'hCAFEBABE, 32'h0);
        run_req("LB",   LOAD_DATA,  LS_B,  32'h200, 32'd3, 32'h0, 1, 32'h80123456,
                32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
        run_req("LBU",  LOAD_DATA,  LS_BU, 32'h200, 32'd3, 32'h0, 0, 32'h80123456,
                32'h200, 4'b1000, 32'h0, 32'h00000080);
        run_req("LH",   LOAD_DATA,  LS_H,  32'h202, 32'd0, 32'h0, 0, 32'h9ABC1234,
                32'h200, 4'b1100, 32'h0, 32'hFFFF9ABC);
        run_req("LHU",  LOAD_DATA,  LS_HU, 32'h202, 32'd0, 32'h0, 2, 32'h9ABC1234,
                32'h200, 4'b1100, 32'h0, 32'h00009ABC);
        run_req("LHlo", LOAD_DATA,  LS_H,  32'h200, 32'd0, 32'h0, 0, 32'h80007FFF,
                32'h200, 4'b0011, 32'h0, 32'h00007FFF);
        run_req("SB",   STORE_DATA, LS_B,  32'h300, 32'd1, 32'h000000A5, 0, 32'h0,
                32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0);
        run_req("SH",   STORE_DATA, LS_H,  32'h400, 32'd2, 32'h1234BEEF, 1, 32'h0,
                32'h400, 4'b1100, 32'hBEEFBEEF, 32'h0);
        run_req("LWneg", LOAD_DATA, LS_W,  32'h1000, 32'hFFFFFFFC, 32'h0, 0, 32'h12345678,
                32'h0FFC, 4'b1111, 32'h0, 32'h12345678);
        run_req("LWres", LOAD_DATA, 3'b111, 32'h208, 32'd0, 32'h0, 0, 32'h89ABCDEF,
                32'h208, 4'b1111, 32'h0, 32'h89ABCDEF);

        // Timeout: slave never answers; 8 BUS cycles then abort
        @(negedge clk);
        cyc = 1'b1; memory_operation = LOAD_DATA; funct3 = LS_W; rs1_data = 32'h500; offset = 32'h0;
        @(negedge clk);
        n = 0;
        while (wb_cyc_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("tmo bus_cycles", 32'(n), 32'd8);
        chk("tmo cyc_drop", 32'(wb_cyc_o), 32'd0);
        chk("tmo ack", 32'(ack), 32'd1);
        chk("tmo berr", 32'(bus_error), 32'd1);
        cyc = 1'b0; memory_operation = MEM_NONE;
        @(negedge clk);
        chk("tmo dv", 32'(data_valid), 32'd1);
        chk("tmo ld", load_data, 32'h0);
        chk("tmo berr_sticky", 32'(bus_error), 32'd1);
        // run_req checks bus_error cleared on acceptance
        run_req("LWpost", LOAD_DATA, LS_W, 32'h600, 32'd0, 32'h0, 0, 32'h0BADF00D,
                32'h600, 4'b1111, 32'h0, 32'h0BADF00D);

        // Slave error termination
        @(negedge clk);
        cyc = 1'b1; memory_operation = LOAD_DATA; funct3 = LS_W; rs1_data = 32'h700; offset = 32'h0;
        @(negedge clk);
        wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        wb_err_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        chk("err ack", 32'(ack), 32'd1);
        chk("err berr", 32'(bus_error), 32'd1);
        cyc = 1'b0; memory_operation = MEM_NONE;
        @(negedge clk);
        chk("err ld", load_data, 32'h0);
        @(negedge clk);

        // Reset mid-BUS drops the cycle at once
        cyc = 1'b1; memory_operation = LOAD_DATA; funct3 = LS_W; rs1_data = 32'h80; offset = 32'h0;
        @(negedge clk);
        chk("rbus cyc", 32'(wb_cyc_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rbus cyc_drop", 32'(wb_cyc_o), 32'd0);
        chk("rbus ack", 32'(ack), 32'd0);
        cyc = 1'b0; memory_operation = MEM_NONE;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rbus ack_after", 32'(ack), 32'd0);
        run_req("LWrst", LOAD_DATA, LS_W, 32'h40, 32'd0, 32'h0, 0, 32'h55AA55AA,
                32'h40, 4'b1111, 32'h0, 32'h55AA55AA);

`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        cyc = 1'b1; memory_operation = LOAD_DATA; funct3 = LS_W; rs1_data = 32'h102; offset = 32'h0;
        @(negedge clk);
        chk("mis cyc", 32'(wb_cyc_o), 32'd0);
        chk("mis ack", 32'(ack), 32'd1);
        chk("mis flag", 32'(misaligned), 32'd1);
        chk("mis berr", 32'(bus_error), 32'd1);
        cyc = 1'b0; memory_operation = MEM_NONE;
        @(negedge clk);
        chk("mis ack_off", 32'(ack), 32'd0);
        chk("mis ld", load_data, 32'h0);
        @(negedge clk);
`else
        run_req("LWmis", LOAD_DATA, LS_W, 32'h102, 32'd0, 32'h0, 0, 32'hA1B2C3D4,
                32'h100, 4'b1111, 32'h0, 32'hA1B2C3D4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
